// File: rtl/gate_sweep_ctrl_if.sv
// Handshake and gate-drive bundle for gate_sweep_ctrl.
// The slave side is the sequencer; the master side is the board or bench plus the gate under test.
interface gate_sweep_ctrl_if;
  logic       start;
  logic [1:0] op_sel;
  logic       gate_a;
  logic       gate_b;
  logic       gate_c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic       sticky_fail;

  modport master (
    output start, op_sel, gate_c,
    input  gate_a, gate_b, busy, done, pass, err_count, fail_vec, sticky_fail
  );

  modport slave (
    input  start, op_sel, gate_c,
    output gate_a, gate_b, busy, done, pass, err_count, fail_vec, sticky_fail
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive 2-input gate sweep sequencer with settle-time hold and a reference compare.
// Optional GATE_SWEEP_STICKY_EN builds a failure accumulator that is cleared only by rst_n.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  gate_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FIN = 2'd2} state_e;

  localparam logic [7:0] SettleCnt = 8'(SETTLE_CYCLES);

  function automatic logic exp_fn(input logic [1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~(a & b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d, op_q, op_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] wcnt_q, wcnt_d, err_count_q, err_count_d;
  logic [3:0] wvec_q, wvec_d, fail_vec_q, fail_vec_d;
  logic       gate_a_q, gate_a_d, gate_b_q, gate_b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic       step_s;
  logic [1:0] cur_idx_s, cur_op_s;
  logic [7:0] cur_cnt_s;
  logic [2:0] cur_wcnt_s;
  logic [3:0] cur_wvec_s;

  // Next-state logic. IDLE drives vector 00, so the accept cycle already counts
  // as the first cycle of vector 0's settle window (shared step below).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    wvec_d      = wvec_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    pass_d      = pass_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    step_s      = 1'b0;
    cur_idx_s   = idx_q;
    cur_op_s    = op_q;
    cur_cnt_s   = cnt_q;
    cur_wcnt_s  = wcnt_q;
    cur_wvec_s  = wvec_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          step_s     = 1'b1;
          cur_idx_s  = 2'd0;
          cur_op_s   = bus.op_sel;
          cur_cnt_s  = SettleCnt;
          cur_wcnt_s = 3'd0;
          cur_wvec_s = 4'd0;
          op_d       = bus.op_sel;
          busy_d     = 1'b1;
          state_d    = HOLD;
        end else begin
          busy_d = 1'b0;
        end
      end
      HOLD: begin
        step_s = 1'b1;
      end
      FIN: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        err_count_d = wcnt_q;
        fail_vec_d  = wvec_q;
        pass_d      = (wcnt_q == 3'd0);
        state_d     = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (step_s) begin
      idx_d  = cur_idx_s;
      wcnt_d = cur_wcnt_s;
      wvec_d = cur_wvec_s;
      if (cur_cnt_s != 8'd0) begin
        cnt_d = cur_cnt_s - 8'd1;
      end else begin
        if (bus.gate_c != exp_fn(cur_op_s, cur_idx_s[1], cur_idx_s[0])) begin
          wcnt_d = cur_wcnt_s + 3'd1;
          wvec_d = cur_wvec_s | (4'd1 << cur_idx_s);
        end else begin
          wvec_d = cur_wvec_s;
        end
        if (cur_idx_s != 2'd3) begin
          idx_d = cur_idx_s + 2'd1;
          cnt_d = SettleCnt;
        end else begin
          state_d = FIN;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end

    gate_a_d = (state_d == HOLD) ? idx_d[1] : 1'b0;
    gate_b_d = (state_d == HOLD) ? idx_d[0] : 1'b0;
  end

  // State and output registers; reset aborts any sweep without publishing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      op_q        <= 2'd0;
      cnt_q       <= 8'd0;
      wcnt_q      <= 3'd0;
      wvec_q      <= 4'd0;
      err_count_q <= 3'd0;
      fail_vec_q  <= 4'd0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      wvec_q      <= wvec_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
    end
  end

  assign bus.gate_a    = gate_a_q;
  assign bus.gate_b    = gate_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.fail_vec  = fail_vec_q;

`ifdef GATE_SWEEP_STICKY_EN
  logic sticky_q;

  // Latches any failing sweep until the next rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if ((state_q == FIN) && (wcnt_q != 3'd0)) begin
      sticky_q <= 1'b1;
    end else begin
      sticky_q <= sticky_q;
    end
  end

  assign bus.sticky_fail = sticky_q;
`else
  assign bus.sticky_fail = 1'b0;
`endif
endmodule
